// File: rtl/fifo_pkg.sv
// Shared FIFO helpers: pointer wrap, width
// helpers and the registered status flag bundle.
package fifo_pkg;

   typedef enum logic {
      RD_NORMAL     = 1'b0,
      RD_SHOW_AHEAD = 1'b1
   } rd_mode_e;

   typedef struct packed {
      logic full;
      logic almost_full;
      logic mty;
      logic almost_mty;
      logic ovf;
      logic udf;
   } fifo_flags_t;

   localparam fifo_flags_t FLAGS_RST = '{
      full:        1'b0,
      almost_full: 1'b0,
      mty:         1'b1,
      almost_mty:  1'b1,
      ovf:         1'b0,
      udf:         1'b0
   };

   // Pointer width; never below one bit.
   function automatic int unsigned pw_of(
      input int unsigned depth
   );
      return (depth < 2) ? 1 : $clog2(depth);
   endfunction

   // Counter width able to hold 0..depth.
   function automatic int unsigned cw_of(
      input int unsigned depth
   );
      return $clog2(depth + 1);
   endfunction

   // Wrap by compare so any depth works.
   function automatic int unsigned ptr_inc(
      input int unsigned ptr,
      input int unsigned depth
   );
      return (ptr + 1 >= depth) ? 0 : ptr + 1;
   endfunction

endpackage

// File: rtl/sync_fifo_if.sv
// Write/read handshake and status bundle
// between a producer/consumer and sync_fifo.
interface sync_fifo_if
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 128,
   parameter int DEPTH      = 8
) ();

   localparam int CW = cw_of(DEPTH);

   logic                  wr;
   logic [DATA_WIDTH-1:0] data;
   logic                  rd;
   logic [DATA_WIDTH-1:0] q;
   logic [CW-1:0]         usedw;
   logic                  full;
   logic                  almost_full;
   logic                  mty;
   logic                  almost_mty;
   logic                  ovf;
   logic                  udf;

   modport master (
      output wr, data, rd,
      input  q, usedw, full, almost_full,
      input  mty, almost_mty, ovf, udf
   );

   modport slave (
      input  wr, data, rd,
      output q, usedw, full, almost_full,
      output mty, almost_mty, ovf, udf
   );

endinterface

// File: rtl/sync_fifo_ram.sv
// 1W1R register array behind sync_fifo;
// kept separate so a RAM macro can replace it.
module fifo_ram
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 128,
   parameter int DEPTH      = 8,
   localparam int PW        = pw_of(DEPTH)
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [PW-1:0]         waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [PW-1:0]         raddr,
   output logic [DATA_WIDTH-1:0] rdata_comb
);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   // Storage write; contents survive resets.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata_comb = mem_q[raddr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO: pointers, occupancy,
// registered flags, error pulses, read port.
module sync_fifo
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH  = 128,
   parameter int DEPTH       = 8,
   parameter int SHOW_AHEAD  = 0,
   parameter int ALMOST_FULL = 1,
   parameter int ALMOST_MTY  = 1
) (
   input logic        clk,
   input logic        arst,
   input logic        srst,
   sync_fifo_if.slave bus
);

   localparam int PW = pw_of(DEPTH);
   localparam int CW = cw_of(DEPTH);

   localparam rd_mode_e RD_MODE =
      (SHOW_AHEAD != 0) ? RD_SHOW_AHEAD : RD_NORMAL;

   localparam logic [CW-1:0] AF_LVL =
      CW'(DEPTH - ALMOST_FULL);
   localparam logic [CW-1:0] AM_LVL =
      CW'(ALMOST_MTY);
   localparam logic [CW-1:0] FULL_LVL =
      CW'(DEPTH);

   if (DEPTH < 2) begin : g_bad_depth
      $error("sync_fifo: DEPTH must be >= 2");
   end
   if (ALMOST_FULL >= DEPTH) begin : g_bad_af
      $error("sync_fifo: ALMOST_FULL >= DEPTH");
   end
   if (ALMOST_MTY >= DEPTH) begin : g_bad_am
      $error("sync_fifo: ALMOST_MTY >= DEPTH");
   end

   logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]         usedw_q, usedw_d;
   fifo_flags_t           flags_q, flags_d;
   logic                  wr_acc;
   logic                  rd_acc;
   logic                  ram_we;
   logic [DATA_WIDTH-1:0] rdata;

   // Acceptance uses last cycle's flags only.
   assign wr_acc = bus.wr & ~flags_q.full;
   assign rd_acc = bus.rd & ~flags_q.mty;
   assign ram_we = wr_acc & ~srst;

   // Next pointers, occupancy and flags.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      usedw_d  = usedw_q;
      flags_d  = flags_q;
      if (srst) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         usedw_d  = '0;
         flags_d  = FLAGS_RST;
      end else begin
         if (wr_acc) begin
            wr_ptr_d = PW'(ptr_inc(
               32'(wr_ptr_q), DEPTH));
         end
         if (rd_acc) begin
            rd_ptr_d = PW'(ptr_inc(
               32'(rd_ptr_q), DEPTH));
         end
         unique case ({wr_acc, rd_acc})
            2'b10:   usedw_d = usedw_q + CW'(1);
            2'b01:   usedw_d = usedw_q - CW'(1);
            default: usedw_d = usedw_q;
         endcase
         flags_d.full        = usedw_d == FULL_LVL;
         flags_d.almost_full = usedw_d >= AF_LVL;
         flags_d.mty         = usedw_d == '0;
         flags_d.almost_mty  = usedw_d <= AM_LVL;
         flags_d.ovf = bus.wr & flags_q.full;
         flags_d.udf = bus.rd & flags_q.mty;
      end
   end

   // Control state register.
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         usedw_q  <= '0;
         flags_q  <= FLAGS_RST;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         usedw_q  <= usedw_d;
         flags_q  <= flags_d;
      end
   end

   fifo_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
   ) u_ram (
      .clk        (clk),
      .we         (ram_we),
      .waddr      (wr_ptr_q),
      .wdata      (bus.data),
      .raddr      (rd_ptr_q),
      .rdata_comb (rdata)
   );

   if (RD_MODE == RD_NORMAL) begin : g_q_reg
      logic [DATA_WIDTH-1:0] q_q, q_d;

      // Capture head word on an accepted read.
      always_comb begin
         q_d = q_q;
         if (srst) begin
            q_d = '0;
         end else if (rd_acc) begin
            q_d = rdata;
         end
      end

      // Read data register.
      always_ff @(posedge clk or posedge arst) begin
         if (arst) begin
            q_q <= '0;
         end else begin
            q_q <= q_d;
         end
      end

      assign bus.q = q_q;
   end else begin : g_q_comb
      assign bus.q = rdata;
   end

   assign bus.usedw       = usedw_q;
   assign bus.full        = flags_q.full;
   assign bus.almost_full = flags_q.almost_full;
   assign bus.mty         = flags_q.mty;
   assign bus.almost_mty  = flags_q.almost_mty;
   assign bus.ovf         = flags_q.ovf;
   assign bus.udf         = flags_q.udf;

endmodule

// File: tb/tb_sync_fifo.sv
// Bench for sync_fifo: three configurations
// against a shift-list occupancy model.
module tb_sync_fifo;

   logic clk  = 1'b0;
   logic arst = 1'b0;
   always #5 clk = ~clk;

   logic [2:0]   srst_v = '0;
   logic [2:0]   wr_v   = '0;
   logic [2:0]   rd_v   = '0;
   logic [127:0] data_v [3];

   logic [127:0] q_v [3];
   logic [3:0]   usedw_v [3];
   logic [2:0]   full_v, af_v, mty_v;
   logic [2:0]   am_v, ovf_v, udf_v;

   sync_fifo_if #(.DATA_WIDTH(128), .DEPTH(8)) b0 ();
   sync_fifo_if #(.DATA_WIDTH(128), .DEPTH(5)) b1 ();
   sync_fifo_if #(.DATA_WIDTH(128), .DEPTH(4)) b2 ();

   assign b0.wr = wr_v[0];
   assign b0.rd = rd_v[0];
   assign b0.data = data_v[0];
   assign b1.wr = wr_v[1];
   assign b1.rd = rd_v[1];
   assign b1.data = data_v[1];
   assign b2.wr = wr_v[2];
   assign b2.rd = rd_v[2];
   assign b2.data = data_v[2];

   assign q_v[0] = b0.q;
   assign q_v[1] = b1.q;
   assign q_v[2] = b2.q;
   assign usedw_v[0] = b0.usedw;
   assign usedw_v[1] = 4'(b1.usedw);
   assign usedw_v[2] = 4'(b2.usedw);
   assign full_v = {b2.full, b1.full, b0.full};
   assign af_v = {b2.almost_full,
                  b1.almost_full, b0.almost_full};
   assign mty_v = {b2.mty, b1.mty, b0.mty};
   assign am_v = {b2.almost_mty,
                  b1.almost_mty, b0.almost_mty};
   assign ovf_v = {b2.ovf, b1.ovf, b0.ovf};
   assign udf_v = {b2.udf, b1.udf, b0.udf};

   sync_fifo #(
      .DATA_WIDTH(128), .DEPTH(8), .SHOW_AHEAD(0),
      .ALMOST_FULL(1), .ALMOST_MTY(1)
   ) u0 (
      .clk(clk), .arst(arst),
      .srst(srst_v[0]), .bus(b0)
   );

   sync_fifo #(
      .DATA_WIDTH(128), .DEPTH(5), .SHOW_AHEAD(0),
      .ALMOST_FULL(1), .ALMOST_MTY(1)
   ) u1 (
      .clk(clk), .arst(arst),
      .srst(srst_v[1]), .bus(b1)
   );

   sync_fifo #(
      .DATA_WIDTH(128), .DEPTH(4), .SHOW_AHEAD(1),
      .ALMOST_FULL(1), .ALMOST_MTY(1)
   ) u2 (
      .clk(clk), .arst(arst),
      .srst(srst_v[2]), .bus(b2)
   );

   // Model: ordered word list per FIFO, head at 0.
   int           dep [3] = '{8, 5, 4};
   bit           sa  [3] = '{1'b0, 1'b0, 1'b1};
   logic [127:0] mw  [3][8];
   int           cnt [3];
   logic [127:0] qreg [3];
   bit           eovf [3];
   bit           eudf [3];

   int tests = 0;
   int fails = 0;

   task automatic chk(
      input string        tag,
      input int           i,
      input logic [127:0] obs,
      input logic [127:0] exp
   );
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL d%0d.%s observed=%0h expected=%0h",
                i, tag, obs, exp);
      end
   endtask

   task automatic check(input int i);
      chk("usedw", i, usedw_v[i], cnt[i]);
      chk("full", i, full_v[i], cnt[i] == dep[i]);
      chk("almost_full", i, af_v[i],
          cnt[i] >= dep[i] - 1);
      chk("mty", i, mty_v[i], cnt[i] == 0);
      chk("almost_mty", i, am_v[i], cnt[i] <= 1);
      chk("ovf", i, ovf_v[i], eovf[i]);
      chk("udf", i, udf_v[i], eudf[i]);
      if (!sa[i]) begin
         chk("q", i, q_v[i], qreg[i]);
      end else if (cnt[i] > 0) begin
         chk("q_head", i, q_v[i], mw[i][0]);
      end
   endtask

   task automatic model_reset(input int i);
      cnt[i]  = 0;
      eovf[i] = 1'b0;
      eudf[i] = 1'b0;
      qreg[i] = '0;
   endtask

   task automatic step(
      input int           i,
      input logic         w,
      input logic         r,
      input logic [127:0] d,
      input logic         s
   );
      bit f;
      bit e;
      @(negedge clk);
      wr_v[i]   = w;
      rd_v[i]   = r;
      data_v[i] = d;
      srst_v[i] = s;
      @(posedge clk);
      f = cnt[i] == dep[i];
      e = cnt[i] == 0;
      if (s) begin
         model_reset(i);
      end else begin
         eovf[i] = w && f;
         eudf[i] = r && e;
         if (r && !e) begin
            qreg[i] = mw[i][0];
            for (int k = 0; k < 7; k++) begin
               mw[i][k] = mw[i][k+1];
            end
            cnt[i]--;
         end
         if (w && !f) begin
            mw[i][cnt[i]] = d;
            cnt[i]++;
         end
      end
      #1;
      check(i);
      wr_v[i]   = 1'b0;
      rd_v[i]   = 1'b0;
      srst_v[i] = 1'b0;
   endtask

   initial begin
      logic [127:0] qsave;
      for (int i = 0; i < 3; i++) begin
         data_v[i] = '0;
         model_reset(i);
      end

      arst = 1'b1;
      #12;
      for (int i = 0; i < 3; i++) check(i);
      @(negedge clk);
      arst = 1'b0;

      // Fill DEPTH 8 with 1..8, then drain.
      for (int k = 1; k <= 8; k++) begin
         step(0, 1'b1, 1'b0, 128'(k), 1'b0);
         if (k == 7) begin
            chk("af_at7", 0, af_v[0], 1'b1);
            chk("full_at7", 0, full_v[0], 1'b0);
         end
      end
      chk("full_at8", 0, full_v[0], 1'b1);
      chk("usedw_at8", 0, usedw_v[0], 4'd8);
      for (int k = 1; k <= 8; k++) begin
         step(0, 1'b0, 1'b1, '0, 1'b0);
         chk("q_order", 0, q_v[0], 128'(k));
      end
      chk("mty_drained", 0, mty_v[0], 1'b1);

      // Full with wr and rd together.
      for (int k = 0; k < 8; k++) begin
         step(0, 1'b1, 1'b0, 128'(16 + k), 1'b0);
      end
      step(0, 1'b1, 1'b1, 128'hAA, 1'b0);
      chk("ovf_pulse", 0, ovf_v[0], 1'b1);
      chk("usedw_8to7", 0, usedw_v[0], 4'd7);
      step(0, 1'b0, 1'b0, '0, 1'b0);
      chk("ovf_clear", 0, ovf_v[0], 1'b0);
      for (int k = 0; k < 7; k++) begin
         step(0, 1'b0, 1'b1, '0, 1'b0);
      end
      chk("last_not_aa", 0, q_v[0], 128'd23);

      // Empty with wr and rd together.
      qsave = qreg[0];
      step(0, 1'b1, 1'b1, 128'h55, 1'b0);
      chk("udf_pulse", 0, udf_v[0], 1'b1);
      chk("usedw_udf", 0, usedw_v[0], 4'd1);
      chk("q_hold_udf", 0, q_v[0], qsave);
      step(0, 1'b0, 1'b1, '0, 1'b0);
      chk("q_55", 0, q_v[0], 128'h55);

      // DEPTH 5: steady occupancy 3 across wrap.
      for (int k = 0; k < 3; k++) begin
         step(1, 1'b1, 1'b0, 128'(256 + k), 1'b0);
      end
      for (int k = 3; k < 12; k++) begin
         step(1, 1'b1, 1'b1, 128'(256 + k), 1'b0);
      end
      for (int k = 0; k < 3; k++) begin
         step(1, 1'b0, 1'b1, '0, 1'b0);
      end
      chk("d5_last", 1, q_v[1], 128'(256 + 11));

      // Show-ahead DEPTH 4.
      step(2, 1'b1, 1'b0, 128'h10, 1'b0);
      chk("sa_first", 2, q_v[2], 128'h10);
      step(2, 1'b1, 1'b0, 128'h20, 1'b0);
      step(2, 1'b0, 1'b1, '0, 1'b0);
      chk("sa_next", 2, q_v[2], 128'h20);
      step(2, 1'b0, 1'b1, '0, 1'b0);
      chk("sa_mty", 2, mty_v[2], 1'b1);

      // srst with wr while holding 3 words.
      for (int k = 0; k < 3; k++) begin
         step(0, 1'b1, 1'b0, 128'(48 + k), 1'b0);
      end
      step(0, 1'b1, 1'b0, 128'hBB, 1'b1);
      chk("srst_usedw", 0, usedw_v[0], 4'd0);
      chk("srst_mty", 0, mty_v[0], 1'b1);
      chk("srst_ovf", 0, ovf_v[0], 1'b0);

      // Randomised mix on all three FIFOs.
      for (int n = 0; n < 600; n++) begin
         int   i;
         logic w;
         logic r;
         logic s;
         i = int'($urandom_range(0, 2));
         if (n < 300) begin
            w = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 3) == 0);
         end else begin
            w = ($urandom_range(0, 1) != 0);
            r = ($urandom_range(0, 1) != 0);
         end
         s = ($urandom_range(0, 31) == 0);
         step(i, w, r, {$urandom, $urandom,
                        $urandom, $urandom}, s);
      end

      // arst in mid-cycle with words held.
      for (int k = 0; k < 3; k++) begin
         step(0, 1'b1, 1'b0, 128'(64 + k), 1'b0);
         step(2, 1'b1, 1'b0, 128'(80 + k), 1'b0);
      end
      @(negedge clk);
      #2;
      arst = 1'b1;
      for (int i = 0; i < 3; i++) model_reset(i);
      #1;
      for (int i = 0; i < 3; i++) check(i);
      #1;
      arst = 1'b0;
      step(0, 1'b1, 1'b0, 128'hCC, 1'b0);
      step(0, 1'b0, 1'b1, '0, 1'b0);
      chk("post_arst", 0, q_v[0], 128'hCC);
      step(2, 1'b1, 1'b0, 128'hDD, 1'b0);
      chk("post_arst_sa", 2, q_v[2], 128'hDD);

      $display("[TB] %0d tests run, %0d failed",
               tests, fails);
      $finish;
   end

endmodule
